// File: rtl/phosphor_trail_gen.sv
// phosphor_trail_gen: VGA pixel-colour generator that draws a moving line
// pattern with a fading phosphor trail. Each pixel's age is the difference
// between the animation counter and a per-pixel key derived from (hpos, vpos).
// Output is a registered 2-bit RGB suitable for the Tiny VGA Pmod.
//
// Handshake note: there is no valid/ready flow here. Pixel coordinates are
// accepted every clock; r/g/b reflect the coordinates presented two clocks
// earlier. vsync is a level whose rising edge is the frame tick.
module phosphor_trail_gen #(
   parameter int CW       = 9,
   parameter int N_LAG    = 15,
   parameter int AGE_HI   = 3,
   parameter int AGE_MID  = 7,
   parameter int H_ACTIVE = 512,
   parameter int V_ACTIVE = 480
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [9:0]    hpos,
   input  logic [9:0]    vpos,
   input  logic          vsync,
   input  logic [1:0]    mode,
   input  logic [1:0]    speed,
   input  logic          pause,
   input  logic          step,
   output logic [1:0]    r,
   output logic [1:0]    g,
   output logic [1:0]    b,
   output logic [CW-1:0] frame_no
);

   localparam logic [10:0] H_LIM    = 11'(H_ACTIVE);
   localparam logic [10:0] V_LIM    = 11'(V_ACTIVE);
   localparam logic [CW:0] LAG_LIM  = (CW+1)'(N_LAG);
   localparam logic [CW:0] HI_LIM   = (CW+1)'(AGE_HI);
   localparam logic [CW:0] MID_LIM  = (CW+1)'(AGE_MID);

   logic          prev_vsync;
   logic          tick;
   logic [2:0]    div;
   logic [2:0]    div_lim;
   logic [1:0]    mode_q;
   logic          step_pend;

   logic [CW-1:0] key_c;
   logic [CW-1:0] key_q;
   logic          win_q;

   logic [CW-1:0] age;
   logic [CW:0]   age_w;
   logic          drawn;
   logic [1:0]    inten;

   assign tick = vsync & ~prev_vsync;

   // Divider terminal count: 2^speed - 1 frame ticks between advances.
   always_comb begin
      div_lim = 3'd0;
      case (speed)
         2'd0: div_lim = 3'd0;
         2'd1: div_lim = 3'd1;
         2'd2: div_lim = 3'd3;
         2'd3: div_lim = 3'd7;
         default: div_lim = 3'd0;
      endcase
   end

   // Frame tick tracking, mode latch, divider, pause/step and frame counter.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         prev_vsync <= 1'b1;
         div        <= 3'd0;
         mode_q     <= 2'b00;
         step_pend  <= 1'b0;
         frame_no   <= '0;
      end else begin
         prev_vsync <= vsync;
         if (tick) begin
            mode_q <= mode;
            if (!pause) begin
               if (div >= div_lim) begin
                  div      <= 3'd0;
                  frame_no <= frame_no + 1'b1;
               end else begin
                  div <= div + 3'd1;
               end
            end else if (step_pend) begin
               // Single-step bypasses the divider entirely.
               div      <= 3'd0;
               frame_no <= frame_no + 1'b1;
            end
         end
         // A step coinciding with the consuming tick is kept for the next one.
         if (!pause)
            step_pend <= 1'b0;
         else if (step)
            step_pend <= 1'b1;
         else if (tick)
            step_pend <= 1'b0;
      end
   end

   // Per-pixel key selected by the frame-stable pattern mode.
   always_comb begin
      key_c = '0;
      case (mode_q)
         2'b00: key_c = hpos[CW-1:0] ^ vpos[CW-1:0];
         2'b01: key_c = hpos[CW-1:0] + vpos[CW-1:0];
         2'b10: key_c = hpos[CW-1:0] - vpos[CW-1:0];
         2'b11: key_c = hpos[CW-1:0];
         default: key_c = '0;
      endcase
   end

   // Stage 1: register key and active-window flag.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         key_q <= '0;
         win_q <= 1'b0;
      end else begin
         key_q <= key_c;
         win_q <= ({1'b0, hpos} < H_LIM) & ({1'b0, vpos} < V_LIM);
      end
   end

   // Age is a single modular subtraction; intensity steps down with age.
   always_comb begin
      age   = frame_no - key_q;
      age_w = {1'b0, age};
      drawn = win_q & (age_w < LAG_LIM);
      if (age_w < HI_LIM)
         inten = 2'd3;
      else if (age_w < MID_LIM)
         inten = 2'd2;
      else
         inten = 2'd1;
   end

   // Stage 2: registered colour; head is cyan, trail is yellow.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r <= 2'd0;
         g <= 2'd0;
         b <= 2'd0;
      end else if (!drawn) begin
         r <= 2'd0;
         g <= 2'd0;
         b <= 2'd0;
      end else if (age == '0) begin
         r <= 2'd0;
         g <= inten;
         b <= inten;
      end else begin
         r <= inten;
         g <= inten;
         b <= 2'd0;
      end
   end

endmodule
